// File: rtl/memwb_stage_if.sv
// Backing-memory request/response bus between the MEM/WB stage (master) and memory (slave).
interface memwb_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/memwb_stage.sv
// MEM/WB pipeline stage with a 2-way set-associative, write-through, no-write-allocate
// word cache in front of a single-request backing memory, plus the W-stage registers.
module memwb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic [4:0]            RdM,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic                  cache_WEM,
    output logic                  StallM,
    memwb_stage_if.master         mem,
    output logic [4:0]            RdW,
    output logic                  RegWriteW,
    output logic [DATA_WIDTH-1:0] ResultW
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = DATA_WIDTH - 2 - IDX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t                state_q, state_d;
    logic [SETS-1:0]       valid_q [2];
    logic [SETS-1:0]       valid_d [2];
    logic [SETS-1:0]       lru_q, lru_d;
    logic [TAG_W-1:0]      tag_q  [2][SETS];
    logic [TAG_W-1:0]      tag_d  [2][SETS];
    logic [DATA_WIDTH-1:0] data_q [2][SETS];
    logic [DATA_WIDTH-1:0] data_d [2][SETS];
    logic [4:0]            rd_w_q, rd_w_d;
    logic                  reg_write_w_q, reg_write_w_d;
    logic [DATA_WIDTH-1:0] result_w_q, result_w_d;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit0, hit1, hit, hit_way, victim;
    logic                  is_store, is_load;
    logic [DATA_WIDTH-1:0] hit_word, alu_sel;

    assign idx      = ALUResultM[2+IDX_W-1:2];
    assign tag      = ALUResultM[DATA_WIDTH-1:2+IDX_W];
    assign is_store = MemWriteM;
    assign is_load  = cache_WEM & ~MemWriteM;
    assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_word = data_q[hit_way][idx];
    assign victim   = !valid_q[0][idx] ? 1'b0 :
                      !valid_q[1][idx] ? 1'b1 : lru_q[idx];
    // Code 01 only means "load data" together with a load; otherwise it falls back to the ALU value.
    assign alu_sel  = (ResultSrcM == 2'b10) ? PCPlus4M : ALUResultM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= '{default: '0};
            lru_q         <= '0;
            rd_w_q        <= '0;
            reg_write_w_q <= 1'b0;
            result_w_q    <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            lru_q         <= lru_d;
            rd_w_q        <= rd_w_d;
            reg_write_w_q <= reg_write_w_d;
            result_w_q    <= result_w_d;
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use of them.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        lru_d         = lru_q;
        tag_d         = tag_q;
        data_d        = data_q;
        rd_w_d        = '0;
        reg_write_w_d = 1'b0;
        result_w_d    = '0;
        case (state_q)
            IDLE: begin
                if (is_store) begin
                    state_d = WR_THRU;
                    if (hit) begin
                        data_d[hit_way][idx] = WriteDataM;
                        lru_d[idx]           = ~hit_way;
                    end
                end else if (is_load) begin
                    if (hit) begin
                        rd_w_d        = RdM;
                        reg_write_w_d = RegWriteM;
                        result_w_d    = hit_word;
                        lru_d[idx]    = ~hit_way;
                    end else begin
                        state_d = RD_MISS;
                    end
                end else begin
                    rd_w_d        = RdM;
                    reg_write_w_d = RegWriteM;
                    result_w_d    = alu_sel;
                end
            end
            RD_MISS: begin
                if (mem.mem_ack) begin
                    state_d                = IDLE;
                    valid_d[victim][idx]   = 1'b1;
                    tag_d[victim][idx]     = tag;
                    data_d[victim][idx]    = mem.mem_rdata;
                    lru_d[idx]             = ~victim;
                    rd_w_d                 = RdM;
                    reg_write_w_d          = RegWriteM;
                    result_w_d             = mem.mem_rdata;
                end
            end
            WR_THRU: begin
                if (mem.mem_ack) begin
                    state_d       = IDLE;
                    rd_w_d        = RdM;
                    reg_write_w_d = RegWriteM;
                    result_w_d    = ALUResultM;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rd_w_d == 5'd0) reg_write_w_d = 1'b0;
    end

    always_comb begin
        StallM       = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        case (state_q)
            IDLE:    StallM = is_store | (is_load & ~hit);
            RD_MISS: begin
                mem.mem_req = 1'b1;
                StallM      = ~mem.mem_ack;
            end
            WR_THRU: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                StallM      = ~mem.mem_ack;
            end
            default: StallM = 1'b0;
        endcase
    end

    assign mem.mem_addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
    assign mem.mem_wdata = WriteDataM;
    assign RdW           = rd_w_q;
    assign RegWriteW     = reg_write_w_q;
    assign ResultW       = result_w_q;
endmodule

// File: tb/tb_memwb_stage.sv
// Randomized bench for memwb_stage: a recency-list cache model and a word-addressed memory
// model predict every cycle's outputs; a few directed sequences pin the model with literals.
module tb_memwb_stage;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]    RdM;
    logic          RegWriteM;
    logic [1:0]    ResultSrcM;
    logic          MemWriteM, cache_WEM;
    logic          StallM;
    logic [4:0]    RdW;
    logic          RegWriteW;
    logic [DW-1:0] ResultW;

    memwb_stage_if #(.DATA_WIDTH(DW)) mem_bus ();

    memwb_stage #(.DATA_WIDTH(DW), .SETS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .cache_WEM  (cache_WEM),
        .StallM     (StallM),
        .mem        (mem_bus.master),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .ResultW    (ResultW)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int stall_count = 0;
    bit chk_en = 1'b0;

    // Expected values for the current cycle, and W-stage values expected after the next edge.
    logic        exp_stall, exp_req, exp_we, exp_bubble, exp_rw;
    logic [31:0] exp_addr, exp_wdata, exp_res;
    logic [4:0]  exp_rd;
    logic        next_bubble, next_rw;
    logic [31:0] next_res;
    logic [4:0]  next_rd;

    // Per set, resident word addresses ordered least- to most-recently used.
    int unsigned lineq [8][$];
    int unsigned mem_model [int unsigned];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelHit(input int unsigned w);
        foreach (lineq[w % 8][i]) if (lineq[w % 8][i] == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void modelTouch(input int unsigned w);
        int unsigned s = w % 8;
        for (int i = 0; i < lineq[s].size(); i++) begin
            if (lineq[s][i] == w) begin
                lineq[s].delete(i);
                break;
            end
        end
        lineq[s].push_back(w);
    endfunction

    function automatic void modelFill(input int unsigned w);
        int unsigned s = w % 8;
        if (lineq[s].size() >= 2) void'(lineq[s].pop_front());
        lineq[s].push_back(w);
    endfunction

    function automatic int unsigned memRead(input int unsigned w);
        if (!mem_model.exists(w)) mem_model[w] = $urandom;
        return mem_model[w];
    endfunction

    function automatic void modelClear();
        for (int s = 0; s < 8; s++) lineq[s].delete();
    endfunction

    task automatic setWb(input logic [4:0] rd, input logic rw, input logic [31:0] res);
        next_bubble = 1'b0;
        next_rd     = rd;
        next_rw     = rw && (rd != 5'd0);
        next_res    = res;
    endtask

    task automatic setBubble();
        next_bubble = 1'b1;
        next_rd     = '0;
        next_rw     = 1'b0;
        next_res    = '0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        exp_bubble = next_bubble;
        exp_rd     = next_rd;
        exp_rw     = next_rw;
        exp_res    = next_res;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (StallM) stall_count++;
            checkOutput("StallM", StallM, exp_stall);
            checkOutput("mem_req", mem_bus.mem_req, exp_req);
            checkOutput("mem_we", mem_bus.mem_we, exp_we);
            if (exp_req) checkOutput("mem_addr", mem_bus.mem_addr, exp_addr);
            if (exp_we) checkOutput("mem_wdata", mem_bus.mem_wdata, exp_wdata);
            checkOutput("RegWriteW", RegWriteW, exp_rw);
            if (!exp_bubble) begin
                checkOutput("RdW", RdW, exp_rd);
                checkOutput("ResultW", ResultW, exp_res);
            end
        end
    end

    // kind: 0 = ALU/no memory op, 1 = load, 2 = store (both enables high when both_en set).
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input logic rw, input logic [1:0] src,
                                 input int wait_cycles, input bit both_en);
        int unsigned w = addr >> 2;
        logic [31:0] data;
        stall_count = 0;
        ALUResultM = addr;
        WriteDataM = wdata;
        PCPlus4M   = $urandom;
        RdM        = rd;
        RegWriteM  = rw;
        ResultSrcM = src;
        MemWriteM  = (kind == 2);
        cache_WEM  = (kind == 1) || (kind == 2 && both_en);
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = $urandom;
        exp_req   = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_wdata = wdata;
        if (kind == 0) begin
            mem_bus.mem_ack = 1'($urandom_range(0, 1));
            exp_stall = 1'b0;
            setWb(rd, rw, (src == 2'b10) ? PCPlus4M : addr);
            stepCycle();
        end else if (kind == 1 && modelHit(w)) begin
            exp_stall = 1'b0;
            setWb(rd, rw, memRead(w));
            modelTouch(w);
            stepCycle();
        end else begin
            exp_stall = 1'b1;
            setBubble();
            if (kind == 2) begin
                if (modelHit(w)) modelTouch(w);
                mem_model[w] = wdata;
            end
            stepCycle();
            exp_req = 1'b1;
            exp_we  = (kind == 2);
            repeat (wait_cycles) begin
                mem_bus.mem_ack   = 1'b0;
                mem_bus.mem_rdata = $urandom;
                exp_stall = 1'b1;
                setBubble();
                stepCycle();
            end
            mem_bus.mem_ack = 1'b1;
            exp_stall = 1'b0;
            if (kind == 1) begin
                data = memRead(w);
                mem_bus.mem_rdata = data;
                setWb(rd, rw, data);
                modelFill(w);
            end else begin
                setWb(rd, rw, addr);
            end
            stepCycle();
        end
        mem_bus.mem_ack = 1'b0;
    endtask

    task automatic driveNoop();
        ALUResultM = '0;
        WriteDataM = '0;
        PCPlus4M   = '0;
        RdM        = '0;
        RegWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        cache_WEM  = 1'b0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        exp_we    = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        driveNoop();
        setWb(5'd0, 1'b0, 32'd0);
        stepCycle();
        rst = 1'b0;
        modelClear();
    endtask

    // Abandon an outstanding read miss; addr must not be cached.
    task automatic resetMidMiss(input logic [31:0] addr);
        ALUResultM = addr;
        RdM        = 5'd7;
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        MemWriteM  = 1'b0;
        cache_WEM  = 1'b1;
        mem_bus.mem_ack = 1'b0;
        exp_stall = 1'b1;
        exp_req   = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = addr & 32'hFFFF_FFFC;
        setBubble();
        stepCycle();
        exp_req = 1'b1;
        setBubble();
        stepCycle();
        rst = 1'b1;
        setWb(5'd0, 1'b0, 32'd0);
        stepCycle();
        rst = 1'b0;
        modelClear();
        driveNoop();
        #1;
        checkOutput("rst_mid mem_req", mem_bus.mem_req, 1'b0);
        checkOutput("rst_mid StallM", StallM, 1'b0);
        checkOutput("rst_mid RegWriteW", RegWriteW, 1'b0);
        setWb(5'd0, 1'b0, 32'd0);
        stepCycle();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        driveNoop();
        repeat (2) @(posedge clk);
        #1;
        doReset();
        chk_en = 1'b1;

        applyStimulus(0, 32'h1234, 32'h0, 5'd5, 1'b1, 2'b00, 0, 1'b0);
        checkOutput("alu RdW", RdW, 5);
        checkOutput("alu RegWriteW", RegWriteW, 1);
        checkOutput("alu ResultW", ResultW, 32'h1234);
        checkOutput("alu stall count", stall_count, 0);

        mem_model[32'h40 >> 2] = 32'hDEADBEEF;
        applyStimulus(1, 32'h40, 32'h0, 5'd3, 1'b1, 2'b01, 2, 1'b0);
        checkOutput("miss stall count", stall_count, 3);
        checkOutput("miss ResultW", ResultW, 32'hDEADBEEF);
        applyStimulus(1, 32'h40, 32'h0, 5'd3, 1'b1, 2'b01, 2, 1'b0);
        checkOutput("hit stall count", stall_count, 0);
        checkOutput("hit ResultW", ResultW, 32'hDEADBEEF);

        doReset();
        applyStimulus(1, 32'h00, 32'h0, 5'd1, 1'b1, 2'b01, 0, 1'b0);
        applyStimulus(1, 32'h20, 32'h0, 5'd2, 1'b1, 2'b01, 0, 1'b0);
        applyStimulus(1, 32'h40, 32'h0, 5'd3, 1'b1, 2'b01, 0, 1'b0);
        applyStimulus(1, 32'h20, 32'h0, 5'd2, 1'b1, 2'b01, 0, 1'b0);
        checkOutput("lru reload 0x20 stall", stall_count, 0);
        applyStimulus(1, 32'h00, 32'h0, 5'd1, 1'b1, 2'b01, 0, 1'b0);
        checkOutput("lru reload 0x00 stall", stall_count, 1);

        doReset();
        applyStimulus(1, 32'h40, 32'h0, 5'd4, 1'b1, 2'b01, 0, 1'b0);
        applyStimulus(2, 32'h40, 32'h55, 5'd0, 1'b0, 2'b00, 1, 1'b0);
        checkOutput("store stall count", stall_count, 2);
        applyStimulus(1, 32'h40, 32'h0, 5'd4, 1'b1, 2'b01, 0, 1'b0);
        checkOutput("store-hit load stall", stall_count, 0);
        checkOutput("store-hit load ResultW", ResultW, 32'h55);
        applyStimulus(2, 32'h80, 32'h77, 5'd0, 1'b0, 2'b00, 0, 1'b1);
        applyStimulus(1, 32'h80, 32'h0, 5'd6, 1'b1, 2'b01, 0, 1'b0);
        checkOutput("no-allocate load stall", stall_count, 1);
        checkOutput("no-allocate load ResultW", ResultW, 32'h77);

        resetMidMiss(32'h100);
        applyStimulus(1, 32'h40, 32'h0, 5'd4, 1'b1, 2'b01, 0, 1'b0);
        checkOutput("post-reset invalid stall", stall_count, 1);

        applyStimulus(1, 32'h44, 32'h0, 5'd0, 1'b1, 2'b01, 1, 1'b0);
        checkOutput("rd0 RegWriteW", RegWriteW, 0);

        for (int n = 0; n < 300; n++) begin
            int          kind;
            int          sel;
            logic [31:0] addr;
            logic [1:0]  src;
            kind = $urandom_range(0, 2);
            addr = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            sel  = $urandom_range(0, 2);
            src  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : 2'b11;
            if (kind == 1) src = 2'b01;
            if (kind == 2) src = 2'b00;
            applyStimulus(kind, addr, $urandom, 5'($urandom_range(0, 31)),
                          (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)), src,
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
